// File: rtl/rec_play_ctrl.sv
// rec_play_ctrl: record/playback sequencer turning key pulses into recorder/DSP commands.
// Latency: commands, state and latches update on the edge that samples the event (keys: 1 cycle, or 3 with edge detect).
// Backpressure: none; one event is acted on per cycle, and lower-priority events in that cycle are dropped.
//
// Optional feature macro: REC_PLAY_CTRL_KEY_EDGE_EN (2-flop sync + rising-edge detect on keys).
//
// Ports:
//   i_clk, i_rst_n            BCLK-domain clock, async active-low reset
//   i_init_done               I2C init finished (level)
//   i_key_0/1/2               record, play, stop keys
//   i_mode, i_speed           play mode and speed-minus-one, latched at play start/resume
//   i_rec_addr, i_play_addr   recorder write / DSP read addresses
//   o_state                   current state encoding
//   o_rec_*/o_dsp_*           single-cycle command pulses
//   o_fast/o_slow_0/o_slow_1  latched mode flags; o_speed latched factor 1..8
//   o_rec_len                 end address of the last completed recording
//   o_sram_sel                1 = recorder owns SRAM, 0 = DSP reads
module rec_play_ctrl #(
   parameter int                ADDR_W   = 20,
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_init_done,
   input  logic              i_key_0,
   input  logic              i_key_1,
   input  logic              i_key_2,
   input  logic [1:0]        i_mode,
   input  logic [2:0]        i_speed,
   input  logic [ADDR_W-1:0] i_rec_addr,
   input  logic [ADDR_W-1:0] i_play_addr,
   output logic [2:0]        o_state,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   output logic              o_dsp_start,
   output logic              o_dsp_pause,
   output logic              o_dsp_stop,
   output logic              o_fast,
   output logic              o_slow_0,
   output logic              o_slow_1,
   output logic [3:0]        o_speed,
   output logic [ADDR_W-1:0] o_rec_len,
   output logic              o_sram_sel
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_I2C        = 3'd1,
      S_RECD       = 3'd2,
      S_RECD_PAUSE = 3'd3,
      S_PLAY       = 3'd4,
      S_PLAY_PAUSE = 3'd5
   } state_t;

   // Key events, bit order {stop, play, record}.
   logic [2:0] key_evt;

`ifdef REC_PLAY_CTRL_KEY_EDGE_EN
   // Raw keys are asynchronous and may be held; synchronise, then fire once on the rising edge.
   logic [2:0] key_meta_q;
   logic [2:0] key_sync_q;
   logic [2:0] key_prev_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         key_meta_q <= 3'b000;
         key_sync_q <= 3'b000;
         key_prev_q <= 3'b000;
      end else begin
         key_meta_q <= {i_key_2, i_key_1, i_key_0};
         key_sync_q <= key_meta_q;
         key_prev_q <= key_sync_q;
      end
   end

   assign key_evt = key_sync_q & ~key_prev_q;
`else
   // Keys arrive as clean single-cycle pulses from the front end.
   assign key_evt = {i_key_2, i_key_1, i_key_0};
`endif

   logic ev_stop;
   logic ev_rec;
   logic ev_play;

   assign ev_stop = key_evt[2];
   assign ev_rec  = key_evt[0];
   assign ev_play = key_evt[1];

   state_t state_q;
   state_t state_d;

   logic rec_start_d;
   logic rec_pause_d;
   logic rec_stop_d;
   logic dsp_start_d;
   logic dsp_pause_d;
   logic dsp_stop_d;
   logic rec_len_ld;
   logic mode_ld;

   // Next-state and command decode. Within each state the if/else chain
   // encodes priority: stop key, record key, play key, then auto events.
   always_comb begin
      state_d     = state_q;
      rec_start_d = 1'b0;
      rec_pause_d = 1'b0;
      rec_stop_d  = 1'b0;
      dsp_start_d = 1'b0;
      dsp_pause_d = 1'b0;
      dsp_stop_d  = 1'b0;
      rec_len_ld  = 1'b0;
      mode_ld     = 1'b0;

      case (state_q)
         S_I2C: begin
            if (i_init_done) begin
               state_d = S_IDLE;
            end
         end

         S_IDLE: begin
            if (ev_stop) begin
               // Nothing to stop; the key still blocks lower-priority keys this cycle.
               state_d = S_IDLE;
            end else if (ev_rec) begin
               state_d     = S_RECD;
               rec_start_d = 1'b1;
            end else if (ev_play && (o_rec_len != '0)) begin
               // Playing an empty clip would end immediately, so the key is ignored.
               state_d     = S_PLAY;
               dsp_start_d = 1'b1;
               mode_ld     = 1'b1;
            end
         end

         S_RECD: begin
            if (ev_stop) begin
               state_d    = S_IDLE;
               rec_stop_d = 1'b1;
               rec_len_ld = 1'b1;
            end else if (ev_rec) begin
               state_d     = S_RECD_PAUSE;
               rec_pause_d = 1'b1;
            end else if (i_rec_addr >= MAX_ADDR) begin
               // SRAM full: behave exactly like a stop key.
               state_d    = S_IDLE;
               rec_stop_d = 1'b1;
               rec_len_ld = 1'b1;
            end
         end

         S_RECD_PAUSE: begin
            if (ev_stop) begin
               state_d    = S_IDLE;
               rec_stop_d = 1'b1;
               rec_len_ld = 1'b1;
            end else if (ev_rec) begin
               state_d     = S_RECD;
               rec_start_d = 1'b1;
            end
         end

         S_PLAY: begin
            if (ev_stop) begin
               state_d    = S_IDLE;
               dsp_stop_d = 1'b1;
            end else if (ev_play) begin
               state_d     = S_PLAY_PAUSE;
               dsp_pause_d = 1'b1;
            end else if (i_play_addr >= o_rec_len) begin
               // Reached the end of the recorded clip.
               state_d    = S_IDLE;
               dsp_stop_d = 1'b1;
            end
         end

         S_PLAY_PAUSE: begin
            if (ev_stop) begin
               state_d    = S_IDLE;
               dsp_stop_d = 1'b1;
            end else if (ev_play) begin
               // Resume re-samples mode/speed so the user can change them while paused.
               state_d     = S_PLAY;
               dsp_start_d = 1'b1;
               mode_ld     = 1'b1;
            end
         end

         default: begin
            state_d = S_I2C;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_I2C;
         o_rec_start <= 1'b0;
         o_rec_pause <= 1'b0;
         o_rec_stop  <= 1'b0;
         o_dsp_start <= 1'b0;
         o_dsp_pause <= 1'b0;
         o_dsp_stop  <= 1'b0;
         o_sram_sel  <= 1'b0;
      end else begin
         state_q     <= state_d;
         o_rec_start <= rec_start_d;
         o_rec_pause <= rec_pause_d;
         o_rec_stop  <= rec_stop_d;
         o_dsp_start <= dsp_start_d;
         o_dsp_pause <= dsp_pause_d;
         o_dsp_stop  <= dsp_stop_d;
         // Taken from the next state so the mux flips together with o_state.
         o_sram_sel  <= (state_d == S_RECD);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rec_len <= '0;
      end else if (rec_len_ld) begin
         o_rec_len <= i_rec_addr;
      end
   end

   // Mode/speed are frozen for the DSP between start/resume events.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_fast   <= 1'b0;
         o_slow_0 <= 1'b0;
         o_slow_1 <= 1'b0;
         o_speed  <= 4'd1;
      end else if (mode_ld) begin
         o_fast   <= (i_mode == 2'b01);
         o_slow_0 <= (i_mode == 2'b10);
         o_slow_1 <= (i_mode == 2'b11);
         // Normal mode always runs at unity speed regardless of i_speed.
         o_speed  <= (i_mode == 2'b00) ? 4'd1 : ({1'b0, i_speed} + 4'd1);
      end
   end

   assign o_state = state_q;

endmodule

// File: tb/tb_rec_play_ctrl.sv
module tb_rec_play_ctrl;

   localparam logic [19:0] MAXA = 20'hFFFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        init_done;
   logic        key_0, key_1, key_2;
   logic [1:0]  mode;
   logic [2:0]  speed;
   logic [19:0] rec_addr, play_addr;

   logic [2:0]  o_state;
   logic        o_rec_start, o_rec_pause, o_rec_stop;
   logic        o_dsp_start, o_dsp_pause, o_dsp_stop;
   logic        o_fast, o_slow_0, o_slow_1;
   logic [3:0]  o_speed;
   logic [19:0] o_rec_len;
   logic        o_sram_sel;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   rec_play_ctrl #(.ADDR_W(20), .MAX_ADDR(20'hFFFFF)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_init_done (init_done),
      .i_key_0     (key_0),
      .i_key_1     (key_1),
      .i_key_2     (key_2),
      .i_mode      (mode),
      .i_speed     (speed),
      .i_rec_addr  (rec_addr),
      .i_play_addr (play_addr),
      .o_state     (o_state),
      .o_rec_start (o_rec_start),
      .o_rec_pause (o_rec_pause),
      .o_rec_stop  (o_rec_stop),
      .o_dsp_start (o_dsp_start),
      .o_dsp_pause (o_dsp_pause),
      .o_dsp_stop  (o_dsp_stop),
      .o_fast      (o_fast),
      .o_slow_0    (o_slow_0),
      .o_slow_1    (o_slow_1),
      .o_speed     (o_speed),
      .o_rec_len   (o_rec_len),
      .o_sram_sel  (o_sram_sel)
   );

   // ---------------- reference model ----------------
   // Behavioural view: "recording" states 2/3 and "playing" states 4/5,
   // with the first accepted event in priority order applied.
   int          m_state;
   bit          m_rs, m_rp, m_rst, m_ds, m_dp, m_dst;
   bit          m_fast, m_s0, m_s1, m_sel;
   logic [3:0]  m_speed;
   logic [19:0] m_len;

   task automatic model_reset();
      m_state = 1;
      {m_rs, m_rp, m_rst, m_ds, m_dp, m_dst} = 6'b0;
      {m_fast, m_s0, m_s1, m_sel} = 4'b0;
      m_speed = 4'd1;
      m_len   = 20'd0;
   endtask

   task automatic model_latch();
      m_fast  = (mode == 2'd1);
      m_s0    = (mode == 2'd2);
      m_s1    = (mode == 2'd3);
      m_speed = (mode == 2'd0) ? 4'd1 : 4'(int'(speed) + 1);
   endtask

   task automatic model_step();
      bit recording, playing;
      if (!rst_n) begin
         model_reset();
         return;
      end
      {m_rs, m_rp, m_rst, m_ds, m_dp, m_dst} = 6'b0;
      recording = (m_state == 2) || (m_state == 3);
      playing   = (m_state == 4) || (m_state == 5);
      if (m_state == 1) begin
         if (init_done) m_state = 0;
      end else if (m_state == 0) begin
         if (key_2) begin
         end else if (key_0) begin
            m_state = 2; m_rs = 1;
         end else if (key_1 && m_len != 0) begin
            m_state = 4; m_ds = 1; model_latch();
         end
      end else if (recording) begin
         if (key_2 || (m_state == 2 && !key_0 && rec_addr >= MAXA)) begin
            m_state = 0; m_rst = 1; m_len = rec_addr;
         end else if (key_0) begin
            if (m_state == 2) begin m_state = 3; m_rp = 1; end
            else begin m_state = 2; m_rs = 1; end
         end
      end else if (playing) begin
         if (key_2) begin
            m_state = 0; m_dst = 1;
         end else if (key_1) begin
            if (m_state == 4) begin m_state = 5; m_dp = 1; end
            else begin m_state = 4; m_ds = 1; model_latch(); end
         end else if (m_state == 4 && play_addr >= m_len) begin
            m_state = 0; m_dst = 1;
         end
      end
      m_sel = (m_state == 2);
   endtask

   function automatic logic [36:0] dut_vec();
      return {o_state, o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause,
              o_dsp_stop, o_fast, o_slow_0, o_slow_1, o_speed, o_rec_len, o_sram_sel};
   endfunction

   function automatic logic [36:0] model_vec();
      return {3'(m_state), m_rs, m_rp, m_rst, m_ds, m_dp, m_dst,
              m_fast, m_s0, m_s1, m_speed, m_len, m_sel};
   endfunction

   // Inputs are changed at negedge; the model sees what the next posedge samples.
   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   task automatic press(input bit a0, input bit a1, input bit a2);
      key_0 = a0; key_1 = a1; key_2 = a2;
      tick();
      key_0 = 0; key_1 = 0; key_2 = 0;
   endtask

   // ---------------- tests ----------------
   localparam logic [36:0] RESET_VEC = {3'd1, 6'b0, 3'b0, 4'd1, 20'd0, 1'b0};

   task automatic test_reset();
      rst_n = 0; init_done = 0; key_0 = 0; key_1 = 0; key_2 = 0;
      mode = 0; speed = 0; rec_addr = 0; play_addr = 0;
      model_reset();
      @(negedge clk); @(negedge clk);
      n_total++;
      if (dut_vec() !== RESET_VEC) $display("FAIL reset_vals: got %h want %h", dut_vec(), RESET_VEC);
      else n_pass++;
      rst_n = 1;
      for (int i = 0; i < 4; i++) tick();
      n_total++;
      if (o_state !== 3'd1) $display("FAIL i2c_wait: state got %0d want 1", o_state);
      else n_pass++;
   endtask

   task automatic test_init();
      init_done = 1;
      tick();
      n_total++;
      if (o_state !== 3'd0) $display("FAIL init_done: state got %0d want 0", o_state);
      else n_pass++;
   endtask

   task automatic test_play_empty();
      press(0, 1, 0);
      n_total++;
      if ({o_state, o_dsp_start} !== {3'd0, 1'b0})
         $display("FAIL play_empty: state/dsp_start got %0d/%0d want 0/0", o_state, o_dsp_start);
      else n_pass++;
   endtask

   task automatic test_record();
      rec_addr = 20'h0;
      press(1, 0, 0);
      n_total++;
      if ({o_state, o_rec_start, o_sram_sel} !== {3'd2, 1'b1, 1'b1})
         $display("FAIL rec_start: got %b want 01011", {o_state, o_rec_start, o_sram_sel});
      else n_pass++;
      tick();
      n_total++;
      if ({o_state, o_rec_start, o_sram_sel} !== {3'd2, 1'b0, 1'b1})
         $display("FAIL rec_pulse_width: got %b want 01001", {o_state, o_rec_start, o_sram_sel});
      else n_pass++;
      rec_addr = 20'h00400;
      press(0, 0, 1);
      n_total++;
      if ({o_state, o_rec_stop, o_rec_len, o_sram_sel} !== {3'd0, 1'b1, 20'h00400, 1'b0})
         $display("FAIL rec_stop: got state %0d stop %0d len %h sel %0d want 0 1 00400 0",
                  o_state, o_rec_stop, o_rec_len, o_sram_sel);
      else n_pass++;
   endtask

   task automatic test_play();
      mode = 2'b01; speed = 3'd3; play_addr = 0;
      press(0, 1, 0);
      n_total++;
      if ({o_state, o_dsp_start, o_fast, o_slow_0, o_slow_1, o_speed} !== {3'd4, 4'b1100, 4'd4})
         $display("FAIL play_start: got %b want 100110000100",
                  {o_state, o_dsp_start, o_fast, o_slow_0, o_slow_1, o_speed});
      else n_pass++;
      mode = 2'b10; speed = 3'd7;
      tick();
      n_total++;
      if ({o_state, o_dsp_start, o_fast, o_slow_0, o_slow_1, o_speed} !== {3'd4, 4'b0100, 4'd4})
         $display("FAIL play_hold_latch: got %b want 100010000100",
                  {o_state, o_dsp_start, o_fast, o_slow_0, o_slow_1, o_speed});
      else n_pass++;
      play_addr = 20'h003FF;
      tick();
      n_total++;
      if ({o_state, o_dsp_stop} !== {3'd4, 1'b0})
         $display("FAIL play_before_end: state/stop got %0d/%0d want 4/0", o_state, o_dsp_stop);
      else n_pass++;
      play_addr = 20'h00400;
      tick();
      n_total++;
      if ({o_state, o_dsp_stop} !== {3'd0, 1'b1})
         $display("FAIL play_end_clip: state/stop got %0d/%0d want 0/1", o_state, o_dsp_stop);
      else n_pass++;
      play_addr = 0;
   endtask

   task automatic test_rec_pause_stop();
      rec_addr = 20'h00010;
      press(1, 0, 0);
      press(1, 0, 0);
      n_total++;
      if ({o_state, o_rec_pause, o_rec_start, o_sram_sel} !== {3'd3, 3'b100})
         $display("FAIL rec_pause: got %b want 011100", {o_state, o_rec_pause, o_rec_start, o_sram_sel});
      else n_pass++;
      press(1, 0, 0);
      n_total++;
      if ({o_state, o_rec_pause, o_rec_start, o_sram_sel} !== {3'd2, 3'b011})
         $display("FAIL rec_resume: got %b want 010011", {o_state, o_rec_pause, o_rec_start, o_sram_sel});
      else n_pass++;
      rec_addr = 20'h00400;
      press(1, 0, 1);
      n_total++;
      if ({o_state, o_rec_stop, o_rec_pause, o_rec_start, o_rec_len} !== {3'd0, 3'b100, 20'h00400})
         $display("FAIL stop_priority: got state %0d stop/pause/start %b len %h want 0 100 00400",
                  o_state, {o_rec_stop, o_rec_pause, o_rec_start}, o_rec_len);
      else n_pass++;
      press(1, 0, 0);
      press(1, 0, 0);
      rec_addr = 20'h00800;
      press(0, 0, 1);
      n_total++;
      if ({o_state, o_rec_stop, o_rec_len} !== {3'd0, 1'b1, 20'h00800})
         $display("FAIL stop_from_pause: got state %0d stop %0d len %h want 0 1 00800",
                  o_state, o_rec_stop, o_rec_len);
      else n_pass++;
   endtask

   task automatic test_auto_stop();
      rec_addr = 0;
      press(1, 0, 0);
      rec_addr = MAXA;
      tick();
      n_total++;
      if ({o_state, o_rec_stop, o_rec_len, o_sram_sel} !== {3'd0, 1'b1, 20'hFFFFF, 1'b0})
         $display("FAIL auto_stop: got state %0d stop %0d len %h sel %0d want 0 1 fffff 0",
                  o_state, o_rec_stop, o_rec_len, o_sram_sel);
      else n_pass++;
      rec_addr = 0;
   endtask

   task automatic test_reset_mid_play();
      mode = 2'b00; speed = 3'd5; play_addr = 0;
      press(0, 1, 0);
      n_total++;
      if ({o_state, o_dsp_start, o_fast, o_slow_0, o_slow_1, o_speed} !== {3'd4, 4'b1000, 4'd1})
         $display("FAIL play_normal: got %b want 100100000001",
                  {o_state, o_dsp_start, o_fast, o_slow_0, o_slow_1, o_speed});
      else n_pass++;
      press(0, 1, 0);
      n_total++;
      if ({o_state, o_dsp_pause} !== {3'd5, 1'b1})
         $display("FAIL play_pause: state/pause got %0d/%0d want 5/1", o_state, o_dsp_pause);
      else n_pass++;
      mode = 2'b11; speed = 3'd6;
      press(0, 1, 0);
      n_total++;
      if ({o_state, o_dsp_start, o_fast, o_slow_0, o_slow_1, o_speed} !== {3'd4, 4'b1001, 4'd7})
         $display("FAIL play_resume_relatch: got %b want 100100010111",
                  {o_state, o_dsp_start, o_fast, o_slow_0, o_slow_1, o_speed});
      else n_pass++;
      rst_n = 0;
      #1;
      model_reset();
      n_total++;
      if (dut_vec() !== RESET_VEC) $display("FAIL reset_mid_play: got %h want %h", dut_vec(), RESET_VEC);
      else n_pass++;
      @(negedge clk);
      rst_n = 1;
      tick();
      n_total++;
      if (o_state !== 3'd0) $display("FAIL reinit_after_reset: state got %0d want 0", o_state);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         rst_n     = ($urandom_range(0, 63) != 0);
         init_done = ($urandom_range(0, 7) != 0);
         key_0     = ($urandom_range(0, 3) == 0);
         key_1     = ($urandom_range(0, 3) == 0);
         key_2     = ($urandom_range(0, 5) == 0);
         mode      = 2'($urandom_range(0, 3));
         speed     = 3'($urandom_range(0, 7));
         rec_addr  = ($urandom_range(0, 15) == 0) ? MAXA : 20'($urandom_range(1, 255));
         play_addr = 20'($urandom_range(0, 300));
         tick();
         n_total++;
         if (dut_vec() !== model_vec())
            $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
         else n_pass++;
      end
      rst_n = 1; key_0 = 0; key_1 = 0; key_2 = 0;
   endtask

   initial begin
      test_reset();
      test_init();
      test_play_empty();
      test_record();
      test_play();
      test_rec_pause_stop();
      test_auto_stop();
      test_reset_mid_play();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
